// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI read constants, FSM states and requester IDs
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_32    = 3'd2;
  localparam logic [2:0] SIZE_64    = 3'd3;

  localparam int ID_DCACHE = 0;
  localparam int ID_ICACHE = 1;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 read address/data channel bundle
interface axi_rd_arbiter_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [7:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;
  logic [ID_W-1:0] RID;
  logic [63:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/rd_arb_pick.sv
// rtl/rd_arb_pick.sv - hazard-masked, starvation-aware two-port read winner select
module rd_arb_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int SC_W         = 3
) (
  input  logic            arb_en,
  input  logic            m0_req,
  input  logic [31:0]     m0_addr,
  input  logic            m1_req,
  input  logic [31:0]     m1_addr,
  input  logic            wb_pending,
  input  logic [31:0]     wb_addr,
  input  logic [SC_W-1:0] starve_cnt,
  output logic            grant_valid,
  output logic            grant_port,
  output logic [SC_W-1:0] starve_nxt
);

  logic elig0;
  logic elig1;
  logic force1;

  // Eligibility, winner and next starve count; port 0 has priority until port 1 has lost STARVE_LIMIT times in a row
  always_comb begin
    elig0       = m0_req && !(wb_pending && (m0_addr == wb_addr));
    elig1       = m1_req && !(wb_pending && (m1_addr == wb_addr));
    force1      = (starve_cnt == SC_W'(STARVE_LIMIT));
    grant_port  = elig1 && (!elig0 || force1);
    grant_valid = arb_en && (elig0 || elig1);
    starve_nxt  = starve_cnt;
    if (!m1_req) begin
      starve_nxt = '0;
    end else if (grant_valid) begin
      if (grant_port) begin
        starve_nxt = '0;
      end else if (elig1 && !force1) begin
        starve_nxt = starve_cnt + SC_W'(1);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI4 read channel between dcache and icache refills
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int BURST_LEN    = 15,
  parameter int STARVE_LIMIT = 4,
  parameter int ID_W         = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         m0_req,
  input  logic [31:0]  m0_addr,
  input  logic [2:0]   m0_size,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic         m0_done,
  output logic         m0_err,
  input  logic         m1_req,
  input  logic [31:0]  m1_addr,
  input  logic [2:0]   m1_size,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic         m1_done,
  output logic         m1_err,
  output logic [63:0]  rdata,
  input  logic         wb_pending,
  input  logic [31:0]  wb_addr,
  axi_rd_arbiter_if.master axi
);

  localparam int BW   = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;
  localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  rd_state_e       state;
  rd_state_e       state_nxt;
  logic            owner_q;
  logic [31:0]     addr_q;
  logic [2:0]      size_q;
  logic [ID_W-1:0] id_q;
  logic [BW-1:0]   beat_cnt;
  logic [SC_W-1:0] starve_cnt;
  logic [SC_W-1:0] starve_nxt;
  logic            err0_q;
  logic            err1_q;
  logic            grant_valid;
  logic            grant_port;
  logic            beat;
  logic            beat_err;

  rd_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SC_W         (SC_W)
  ) u_pick (
    .arb_en      (state == RD_IDLE),
    .m0_req      (m0_req),
    .m0_addr     (m0_addr),
    .m1_req      (m1_req),
    .m1_addr     (m1_addr),
    .wb_pending  (wb_pending),
    .wb_addr     (wb_addr),
    .starve_cnt  (starve_cnt),
    .grant_valid (grant_valid),
    .grant_port  (grant_port),
    .starve_nxt  (starve_nxt)
  );

  // State register; reset drops straight back to IDLE even mid-burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus beat qualification and protocol-error detection for the current beat
  always_comb begin
    state_nxt = state;
    beat      = 1'b0;
    beat_err  = 1'b0;
    case (state)
      RD_IDLE: begin
        if (grant_valid) state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        if (axi.ARREADY) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        beat     = axi.RVALID;
        beat_err = (axi.RRESP != 2'b00) ||
                   (axi.RID != id_q) ||
                   (axi.RLAST && (beat_cnt != BW'(BURST_LEN))) ||
                   (!axi.RLAST && (beat_cnt == BW'(BURST_LEN)));
        if (axi.RVALID && axi.RLAST) state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Burst context latched at grant, beat counter, starve counter and sticky per-port error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      id_q       <= '0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      if (grant_valid) begin
        owner_q <= grant_port;
        addr_q  <= grant_port ? m1_addr : m0_addr;
        size_q  <= grant_port ? m1_size : m0_size;
        id_q    <= grant_port ? ID_W'(ID_ICACHE) : ID_W'(ID_DCACHE);
        if (grant_port) err1_q <= 1'b0;
        else            err0_q <= 1'b0;
      end
      if ((state == RD_ADDR) && axi.ARREADY) begin
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
      if (beat && beat_err) begin
        if (owner_q) err1_q <= 1'b1;
        else         err0_q <= 1'b1;
      end
    end
  end

  assign axi.ARVALID = (state == RD_ADDR);
  assign axi.RREADY  = (state == RD_DATA);
  assign axi.ARID    = id_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARSIZE  = size_q;
  assign axi.ARLEN   = 8'(BURST_LEN);
  assign axi.ARBURST = BURST_INCR;

  assign rdata     = (state == RD_DATA) ? axi.RDATA : 64'd0;
  assign m0_gnt    = (state != RD_IDLE) && !owner_q;
  assign m1_gnt    = (state != RD_IDLE) && owner_q;
  assign m0_rvalid = beat && !owner_q;
  assign m1_rvalid = beat && owner_q;
  assign m0_done   = beat && axi.RLAST && !owner_q;
  assign m1_done   = beat && axi.RLAST && owner_q;
  assign m0_err    = err0_q;
  assign m1_err    = err1_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic [2:0]  m0_size, m1_size;
  logic        m0_gnt, m0_rvalid, m0_done, m0_err;
  logic        m1_gnt, m1_rvalid, m1_done, m1_err;
  logic [63:0] rdata;
  logic        wb_pending;
  logic [31:0] wb_addr;

  axi_rd_arbiter_if #(.ID_W(4)) axi ();

  axi_rd_arbiter #(.BURST_LEN(15), .STARVE_LIMIT(4), .ID_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_size    (m0_size),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_done    (m0_done),
    .m0_err     (m0_err),
    .m1_req     (m1_req),
    .m1_addr    (m1_addr),
    .m1_size    (m1_size),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_done    (m1_done),
    .m1_err     (m1_err),
    .rdata      (rdata),
    .wb_pending (wb_pending),
    .wb_addr    (wb_addr),
    .axi        (axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          port;
    logic [2:0]  size;
  } ar_t;

  ar_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ar(input logic [31:0] addr, input int port, input logic [2:0] size);
    ar_t e;
    e.addr = addr;
    e.port = port;
    e.size = size;
    exp_q.push_back(e);
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 1) ? m1_gnt : m0_gnt;
  endfunction
  function automatic logic rv_of(input int p);
    return (p == 1) ? m1_rvalid : m0_rvalid;
  endfunction
  function automatic logic done_of(input int p);
    return (p == 1) ? m1_done : m0_done;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 1) ? m1_err : m0_err;
  endfunction

  // Wait for the next AR, compare against the scoreboard, then return nbeats R beats.
  task automatic serve_burst(input int nbeats, input int resp_at, input int dly,
                             input logic [1:0] drop, input int rst_at);
    ar_t         e;
    int          n;
    int          err_at;
    logic [63:0] d;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!axi.ARVALID && n < 100);
    if (!axi.ARVALID) begin
      check("ar_timeout", 64'd0, 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check("araddr", 64'(axi.ARADDR), 64'(e.addr));
    check("arid", 64'(axi.ARID), 64'(e.port));
    check("arlen", 64'(axi.ARLEN), 64'd15);
    check("arsize", 64'(axi.ARSIZE), 64'(e.size));
    check("arburst", 64'(axi.ARBURST), 64'(BURST_INCR));
    check("gnt", 64'(gnt_of(e.port)), 64'd1);
    check("gnt_other", 64'(gnt_of(1 - e.port)), 64'd0);
    check("err_clr_on_gnt", 64'(err_of(e.port)), 64'd0);
    repeat (dly) begin
      @(negedge clk);
      #1;
      check("ar_hold", 64'(axi.ARVALID && axi.ARADDR == e.addr), 64'd1);
    end
    axi.ARREADY = 1'b1;
    @(negedge clk);
    axi.ARREADY = 1'b0;
    err_at = (resp_at >= 0) ? resp_at : ((nbeats != 16) ? nbeats - 1 : -1);
    for (int i = 0; i < nbeats; i++) begin
      d = {$urandom(), $urandom()};
      axi.RVALID = 1'b1;
      axi.RDATA  = d;
      axi.RLAST  = (i == nbeats - 1);
      axi.RRESP  = (i == resp_at) ? 2'b10 : 2'b00;
      axi.RID    = 4'(e.port);
      #1;
      check("rready", 64'(axi.RREADY), 64'd1);
      check("rdata", rdata, d);
      check("rvalid", 64'(rv_of(e.port)), 64'd1);
      check("rvalid_other", 64'(rv_of(1 - e.port)), 64'd0);
      check("done", 64'(done_of(e.port)), 64'(i == nbeats - 1));
      check("err_sticky", 64'(err_of(e.port)), 64'(err_at >= 0 && i > err_at));
      if (i == rst_at) begin
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        #1;
        check("rst_gnt", 64'(gnt_of(e.port)), 64'd0);
        check("rst_rready", 64'(axi.RREADY), 64'd0);
        check("rst_rvalid", 64'(rv_of(e.port)), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_arvalid", 64'(axi.ARVALID), 64'd0);
        check("rst_araddr", 64'(axi.ARADDR), 64'd0);
        break;
      end
      if (i == nbeats - 1) begin
        if (drop[0]) m0_req = 1'b0;
        if (drop[1]) m1_req = 1'b0;
      end
      @(negedge clk);
    end
    axi.RVALID = 1'b0;
    axi.RLAST  = 1'b0;
    axi.RRESP  = 2'b00;
    if (rst_at < 0) begin
      #1;
      check("idle_after_last", 64'(gnt_of(e.port) || axi.ARVALID || axi.RREADY), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0;  m1_addr = '0;
    m0_size = '0;  m1_size = '0;
    wb_pending = 1'b0; wb_addr = '0;
    axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0;
    axi.RRESP = 2'b00; axi.RID = '0; axi.RDATA = 64'hdead_beef_0bad_f00d;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 64'({m0_gnt, m0_rvalid, m0_done, m0_err, m1_gnt, m1_rvalid,
                             m1_done, m1_err, axi.ARVALID, axi.RREADY}), 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_arlen", 64'(axi.ARLEN), 64'd15);
    check("reset_arburst", 64'(axi.ARBURST), 64'd1);
    check("reset_araddr", 64'(axi.ARADDR), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single dcache refill, AR accepted after 2 cycles
    m0_addr = 32'h8000_0040; m0_size = SIZE_64; m0_req = 1'b1;
    push_ar(32'h8000_0040, 0, SIZE_64);
    serve_burst(16, -1, 2, 2'b01, -1);
    check("t1_err", 64'(m0_err), 64'd0);

    // Both ports contend continuously: starvation forces every fifth grant to port 1
    @(negedge clk);
    m0_addr = 32'h8000_0100; m0_size = SIZE_64; m0_req = 1'b1;
    m1_addr = 32'h8000_0200; m1_size = SIZE_32; m1_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      if (g == 4 || g == 9) push_ar(32'h8000_0200, 1, SIZE_32);
      else                  push_ar(32'h8000_0100, 0, SIZE_64);
    end
    for (int g = 0; g < 10; g++) serve_burst(16, -1, g % 2, (g == 9) ? 2'b11 : 2'b00, -1);

    // Write-back hazard blocks port 0 until wb_pending falls
    @(negedge clk);
    wb_pending = 1'b1; wb_addr = 32'h8000_1000;
    m0_addr = 32'h8000_1000; m0_req = 1'b1;
    m1_addr = 32'h8000_2000; m1_req = 1'b1;
    push_ar(32'h8000_2000, 1, SIZE_32);
    serve_burst(16, -1, 0, 2'b10, -1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("hazard_block", 64'(axi.ARVALID || m0_gnt), 64'd0);
    end
    @(negedge clk);
    wb_pending = 1'b0;
    push_ar(32'h8000_1000, 0, SIZE_64);
    @(negedge clk);
    #1;
    check("hazard_release", 64'(axi.ARVALID && m0_gnt), 64'd1);
    serve_burst(16, -1, 0, 2'b01, -1);

    // Early RLAST on beat 10 sets m1_err; the next port-1 grant clears it
    @(negedge clk);
    m1_req = 1'b1;
    push_ar(32'h8000_2000, 1, SIZE_32);
    serve_burst(10, -1, 0, 2'b10, -1);
    check("early_last_err", 64'(m1_err), 64'd1);
    @(negedge clk);
    m1_req = 1'b1;
    push_ar(32'h8000_2000, 1, SIZE_32);
    serve_burst(16, -1, 1, 2'b10, -1);
    check("err_cleared", 64'(m1_err), 64'd0);

    // SLVERR on beat 3 of a dcache burst: all beats still forwarded
    @(negedge clk);
    m0_req = 1'b1;
    push_ar(32'h8000_1000, 0, SIZE_64);
    serve_burst(16, 2, 0, 2'b01, -1);
    check("resp_err", 64'(m0_err), 64'd1);

    // Reset at beat 7 of a burst, then a clean re-grant
    @(negedge clk);
    m0_addr = 32'h8000_3000; m0_req = 1'b1;
    push_ar(32'h8000_3000, 0, SIZE_64);
    serve_burst(16, -1, 0, 2'b00, 6);
    check("rst_err", 64'(m0_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m0_req = 1'b1;
    push_ar(32'h8000_3000, 0, SIZE_64);
    serve_burst(16, -1, 1, 2'b01, -1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
